// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin owner of the shared 8-bit uio pad bus with turnaround parking
// Ports: clk/rst (async, active-high); ena blocks new grants and aborts the current one;
//   req/dir/wdata are per-requester request, direction (1 = drive) and drive byte;
//   gnt one-hot grant, beat = transfer this cycle, rdata/rd_valid = last sampled uio_in byte and its pulse;
//   uio_in/uio_out/uio_oe are the pad pins.
// Build option: define UIO_ARB_TURN_SKIP_EN to skip the park cycles between two sample-only grants.
module uio_bus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int BURST_MAX   = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   dir,
  input  logic [8*NUM_REQ-1:0] wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 beat,
  output logic [7:0]           rdata,
  output logic                 rd_valid,
  input  logic [7:0]           uio_in,
  output logic [7:0]           uio_out,
  output logic [7:0]           uio_oe
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [PW:0]   NR    = (PW+1)'(NUM_REQ);
  localparam logic [BW-1:0] LAST  = BW'(BURST_MAX - 1);
  localparam logic [3:0]    TLOAD = 4'(TURN_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, TURN, GRANT} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] win_q, win_d, rr_q, rr_d, base, pick, rr_next, idx;
  logic [PW:0] win_inc, sum;
  logic dir_q, dir_d, found, in_grant, drive, done, skip, rd_valid_q, rd_valid_d;
  logic [3:0] turn_q, turn_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [7:0] rdata_q, rdata_d;
  assign in_grant   = state_q == GRANT;
  assign drive      = in_grant & dir_q;
  assign gnt        = in_grant ? NUM_REQ'(1) << win_q : '0;
  assign uio_oe     = {8{drive}};
  assign uio_out    = drive ? wdata[{win_q, 3'b000} +: 8] : 8'h00;
  assign beat       = in_grant & req[win_q] & ena;
  // the beat that reaches the cap is also the exit beat, so the counter never wraps
  assign done       = !req[win_q] | !ena | (beat & (bcnt_q == LAST));
  assign win_inc    = {1'b0, win_q} + (PW+1)'(1);
  assign rr_next    = (win_inc == NR) ? '0 : win_inc[PW-1:0];
  // re-arbitration at grant exit already starts from the advanced pointer
  assign base       = in_grant ? rr_next : rr_q;
  assign rd_valid_d = beat;
  assign rdata_d    = beat ? uio_in : rdata_q;
  assign rdata      = rdata_q;
  assign rd_valid   = rd_valid_q;
`ifdef UIO_ARB_TURN_SKIP_EN
  // no pad is driven by either side, so back-to-back sample grants need no park
  assign skip = !dir_q && !dir[pick];
`else
  assign skip = 1'b0;
`endif
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, base} + (PW+1)'(k);
      idx = (sum >= NR) ? PW'(sum - NR) : PW'(sum);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    dir_d   = dir_q;
    turn_d  = turn_q;
    bcnt_d  = bcnt_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: if (ena && found) begin
        state_d = TURN;
        win_d   = pick;
        dir_d   = dir[pick];
        turn_d  = TLOAD;
      end
      TURN: if (!ena) state_d = IDLE;
      else if (turn_q == 4'd0) begin
        state_d = GRANT;
        bcnt_d  = '0;
      end else turn_d = turn_q - 4'd1;
      GRANT: if (done) begin
        rr_d   = rr_next;
        bcnt_d = '0;
        if (ena && found) begin
          win_d   = pick;
          dir_d   = dir[pick];
          turn_d  = TLOAD;
          state_d = skip ? GRANT : TURN;
        end else state_d = IDLE;
      end else if (beat) bcnt_d = bcnt_q + BW'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= '0;
      dir_q      <= 1'b0;
      turn_q     <= '0;
      bcnt_q     <= '0;
      rr_q       <= '0;
      rdata_q    <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      dir_q      <= dir_d;
      turn_q     <= turn_d;
      bcnt_q     <= bcnt_d;
      rr_q       <= rr_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb_uio_bus_arbiter: table-driven scoreboard bench for uio_bus_arbiter
module tb_uio_bus_arbiter;
  logic clk = 1'b0;
  logic rst, ena;
  logic [3:0] req, dir, gnt;
  logic [31:0] wdata;
  logic beat, rd_valid;
  logic [7:0] rdata, uio_in, uio_out, uio_oe;
  int checks = 0;
  int errors = 0;
`ifdef UIO_ARB_TURN_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  typedef struct {
    string tag;
    logic rst, ena;
    logic [3:0] req, dir;
    logic [7:0] uin;
    logic [3:0] gnt;
    logic [7:0] oe, out;
    logic beat, rdv;
    logic [7:0] rdata;
    logic chk_rd;
  } vec_t;
  vec_t tbl[$];
  vec_t exp_q[$];
  uio_bus_arbiter dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .dir(dir), .wdata(wdata),
    .gnt(gnt), .beat(beat), .rdata(rdata), .rd_valid(rd_valid),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic add(input string tag, input logic r, input logic e, input logic [3:0] rq, input logic [3:0] dr,
                     input logic [7:0] uin, input logic [3:0] g, input logic drv, input logic [7:0] out,
                     input logic b, input logic rv, input logic [7:0] rd, input logic c);
    vec_t v;
    v.tag = tag; v.rst = r; v.ena = e; v.req = rq; v.dir = dr; v.uin = uin;
    v.gnt = g; v.oe = drv ? 8'hFF : 8'h00; v.out = out; v.beat = b; v.rdv = rv; v.rdata = rd; v.chk_rd = c;
    tbl.push_back(v);
  endtask
  task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
    end
  endtask
  initial begin
    vec_t e;
    rst = 1'b1; ena = 1'b0; req = 4'h0; dir = 4'h0; uio_in = 8'h00; wdata = 32'h3CA55AC3;
    // reset with all requesters pending, then full-length bursts rotating 0,1,2,3,0
    add("rot", 1, 1, 4'hF, 4'h0, 8'h77, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    add("rot", 0, 1, 4'hF, 4'h0, 8'h77, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    add("rot", 0, 1, 4'hF, 4'h0, 8'h77, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 8; b++)
        add("rot", 0, 1, 4'hF, 4'h0, 8'h77, 4'(1 << (g % 4)), 0, 8'h00, 1,
            (b != 0) || (SKIP && g > 0), (g == 0 && b == 0) ? 8'h00 : 8'h77, 1);
      if (g < 4 && !SKIP) add("rot", 0, 1, 4'hF, 4'h0, 8'h77, 4'h0, 0, 8'h00, 0, 1, 8'h77, 1);
    end
    // requester 2 drives A5 for three beats then releases
    add("wr", 1, 1, 4'h0, 4'h0, 8'h5E, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    add("wr", 0, 1, 4'h4, 4'h4, 8'h5E, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    add("wr", 0, 1, 4'h4, 4'h4, 8'h5E, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    for (int b = 0; b < 3; b++) add("wr", 0, 1, 4'h4, 4'h4, 8'h5E, 4'h4, 1, 8'hA5, 1, 0, 8'h00, 0);
    add("wr", 0, 1, 4'h0, 4'h4, 8'h5E, 4'h4, 1, 8'hA5, 0, 0, 8'h00, 0);
    add("wr", 0, 1, 4'h0, 4'h4, 8'h5E, 4'h0, 0, 8'h00, 0, 0, 8'h00, 0);
    // requester 1 samples 10,11,12
    add("rd", 1, 1, 4'h0, 4'h0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    add("rd", 0, 1, 4'h2, 4'h0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    add("rd", 0, 1, 4'h2, 4'h0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    add("rd", 0, 1, 4'h2, 4'h0, 8'h10, 4'h2, 0, 8'h00, 1, 0, 8'h00, 1);
    add("rd", 0, 1, 4'h2, 4'h0, 8'h11, 4'h2, 0, 8'h00, 1, 1, 8'h10, 1);
    add("rd", 0, 1, 4'h2, 4'h0, 8'h12, 4'h2, 0, 8'h00, 1, 1, 8'h11, 1);
    add("rd", 0, 1, 4'h0, 4'h0, 8'h12, 4'h2, 0, 8'h00, 0, 1, 8'h12, 1);
    add("rd", 0, 1, 4'h0, 4'h0, 8'h12, 4'h0, 0, 8'h00, 0, 0, 8'h12, 1);
    // write by 0 with read by 3 pending: one park cycle between them
    add("turn", 1, 1, 4'h0, 4'h0, 8'h00, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    add("turn", 0, 1, 4'h9, 4'h1, 8'h00, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    add("turn", 0, 1, 4'h9, 4'h1, 8'h00, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    add("turn", 0, 1, 4'h9, 4'h1, 8'h00, 4'h1, 1, 8'hC3, 1, 0, 8'h00, 0);
    add("turn", 0, 1, 4'h9, 4'h1, 8'h00, 4'h1, 1, 8'hC3, 1, 0, 8'h00, 0);
    add("turn", 0, 1, 4'h8, 4'h1, 8'h00, 4'h1, 1, 8'hC3, 0, 0, 8'h00, 0);
    add("turn", 0, 1, 4'h8, 4'h1, 8'h00, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    add("turn", 0, 1, 4'h8, 4'h1, 8'h00, 4'h8, 0, 8'h00, 1, 0, 8'h00, 1);
    add("turn", 0, 1, 4'h0, 4'h1, 8'h00, 4'h8, 0, 8'h00, 0, 1, 8'h00, 1);
    add("turn", 0, 1, 4'h0, 4'h1, 8'h00, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    // ena drop aborts, resumes later; lone requester re-wins after its cap
    add("ena", 1, 1, 4'h0, 4'h0, 8'h42, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    add("ena", 0, 1, 4'h1, 4'h0, 8'h42, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    add("ena", 0, 1, 4'h1, 4'h0, 8'h42, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    add("ena", 0, 1, 4'h1, 4'h0, 8'h42, 4'h1, 0, 8'h00, 1, 0, 8'h00, 1);
    add("ena", 0, 1, 4'h1, 4'h0, 8'h42, 4'h1, 0, 8'h00, 1, 1, 8'h42, 1);
    add("ena", 0, 0, 4'h1, 4'h0, 8'h42, 4'h1, 0, 8'h00, 0, 1, 8'h42, 1);
    add("ena", 0, 0, 4'h1, 4'h0, 8'h42, 4'h0, 0, 8'h00, 0, 0, 8'h42, 1);
    add("ena", 0, 0, 4'h1, 4'h0, 8'h42, 4'h0, 0, 8'h00, 0, 0, 8'h42, 1);
    add("ena", 0, 1, 4'h1, 4'h0, 8'h42, 4'h0, 0, 8'h00, 0, 0, 8'h42, 1);
    add("ena", 0, 1, 4'h1, 4'h0, 8'h42, 4'h0, 0, 8'h00, 0, 0, 8'h42, 1);
    add("cap", 0, 1, 4'h1, 4'h0, 8'h42, 4'h1, 0, 8'h00, 1, 0, 8'h42, 1);
    for (int b = 1; b < 8; b++) add("cap", 0, 1, 4'h1, 4'h0, 8'h42, 4'h1, 0, 8'h00, 1, 1, 8'h42, 1);
    if (!SKIP) add("cap", 0, 1, 4'h1, 4'h0, 8'h42, 4'h0, 0, 8'h00, 0, 1, 8'h42, 1);
    add("cap", 0, 1, 4'h1, 4'h0, 8'h42, 4'h1, 0, 8'h00, 1, SKIP, 8'h42, 1);
    // two sample-only requesters back to back
    add("rr2", 1, 1, 4'h0, 4'h0, 8'h33, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    add("rr2", 0, 1, 4'h3, 4'h0, 8'h33, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    add("rr2", 0, 1, 4'h3, 4'h0, 8'h33, 4'h0, 0, 8'h00, 0, 0, 8'h00, 1);
    add("rr2", 0, 1, 4'h3, 4'h0, 8'h33, 4'h1, 0, 8'h00, 1, 0, 8'h00, 1);
    add("rr2", 0, 1, 4'h2, 4'h0, 8'h33, 4'h1, 0, 8'h00, 0, 1, 8'h33, 1);
    if (!SKIP) add("rr2", 0, 1, 4'h2, 4'h0, 8'h33, 4'h0, 0, 8'h00, 0, 0, 8'h33, 1);
    add("rr2", 0, 1, 4'h2, 4'h0, 8'h33, 4'h2, 0, 8'h00, 1, 0, 8'h33, 1);
    add("rr2", 0, 1, 4'h0, 4'h0, 8'h33, 4'h2, 0, 8'h00, 0, 1, 8'h33, 1);
    add("rr2", 0, 1, 4'h0, 4'h0, 8'h33, 4'h0, 0, 8'h00, 0, 0, 8'h33, 1);
    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; ena = tbl[i].ena; req = tbl[i].req; dir = tbl[i].dir; uio_in = tbl[i].uin;
      exp_q.push_back(tbl[i]);
      #1;
      e = exp_q.pop_front();
      chk({e.tag, ".gnt"}, i, {4'h0, gnt}, {4'h0, e.gnt});
      chk({e.tag, ".oe"}, i, uio_oe, e.oe);
      chk({e.tag, ".out"}, i, uio_out, e.out);
      chk({e.tag, ".beat"}, i, {7'h0, beat}, {7'h0, e.beat});
      if (e.chk_rd) begin
        chk({e.tag, ".rd_valid"}, i, {7'h0, rd_valid}, {7'h0, e.rdv});
        chk({e.tag, ".rdata"}, i, rdata, e.rdata);
      end
    end
    // reset in the middle of a driving grant must release the pads at once
    @(negedge clk);
    rst = 1'b1; req = 4'h0; dir = 4'h0;
    @(negedge clk);
    rst = 1'b0; ena = 1'b1; req = 4'h4; dir = 4'h4;
    for (int k = 0; k < 8 && gnt !== 4'h4; k++) @(negedge clk);
    chk("mid.reach_gnt", 0, {4'h0, gnt}, 8'h04);
    chk("mid.oe_before", 0, uio_oe, 8'hFF);
    #2 rst = 1'b1;
    #1;
    chk("mid.oe_after", 0, uio_oe, 8'h00);
    chk("mid.gnt_after", 0, {4'h0, gnt}, 8'h00);
    chk("mid.out_after", 0, uio_out, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
